// File: rtl/store_unit_if.sv
// Store-unit bus bundle: MEM-stage store handshake plus the data-memory write port.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1; the initiator holds valid and payload stable until then, and dmem_resp_valid is a one-cycle write-complete acknowledge.
interface store_unit_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
);
  logic                       st_valid;
  logic [DATA_ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0]      st_wdata;
  logic [2:0]                 st_funct3;
  logic                       st_ready;
  logic                       stall_MEM;
  logic                       dmem_req_valid;
  logic [DATA_ADDR_WIDTH-1:0] dmem_req_addr;
  logic [DATA_WIDTH-1:0]      dmem_req_wdata;
  logic [3:0]                 dmem_req_wstrb;
  logic                       dmem_req_ready;
  logic                       dmem_resp_valid;
  logic                       store_err;

  // master: pipeline + memory environment; slave: the store unit itself
  modport master (
    output st_valid, st_addr, st_wdata, st_funct3, dmem_req_ready, dmem_resp_valid,
    input  st_ready, stall_MEM, dmem_req_valid, dmem_req_addr, dmem_req_wdata,
           dmem_req_wstrb, store_err
  );

  modport slave (
    input  st_valid, st_addr, st_wdata, st_funct3, dmem_req_ready, dmem_resp_valid,
    output st_ready, stall_MEM, dmem_req_valid, dmem_req_addr, dmem_req_wdata,
           dmem_req_wstrb, store_err
  );
endinterface

// File: rtl/store_unit.sv
// Store unit: lane-aligns sb/sh/sw stores and issues one write per store to data memory.
// STORE_MISALIGN_TRAP_EN: when defined, misaligned sh/sw are rejected with store_err instead of being force-aligned.
module store_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  store_unit_if.slave bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [3:0]                 wstrb_q, wstrb_d;
  logic                       err_q, err_d;

  logic                       accept;
  logic                       illegal;
  logic                       reject;
  logic [1:0]                 lane;
  logic [DATA_WIDTH-1:0]      lane_wdata;
  logic [3:0]                 lane_wstrb;

  assign accept = bus.st_valid & (state_q == IDLE);

  // Offending low address bits are dropped here, so sh/sw always land on their natural lanes.
  always_comb begin
    illegal    = 1'b0;
    lane       = bus.st_addr[1:0];
    lane_wdata = bus.st_wdata;
    lane_wstrb = 4'b1111;
    case (bus.st_funct3)
      3'b000: begin
        lane_wstrb = 4'b0001 << lane;
        lane_wdata = {4{bus.st_wdata[7:0]}};
      end
      3'b001: begin
        lane[0]    = 1'b0;
        lane_wstrb = lane[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{bus.st_wdata[15:0]}};
      end
      3'b010: begin
        lane_wstrb = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((bus.st_funct3 == 3'b001) & bus.st_addr[0]) |
                      ((bus.st_funct3 == 3'b010) & (|bus.st_addr[1:0]));
  assign reject     = illegal | misaligned;
`else
  assign reject     = illegal;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d = REQ;
            addr_d  = {bus.st_addr[DATA_ADDR_WIDTH-1:2], 2'b00};
            wdata_d = lane_wdata;
            wstrb_d = lane_wstrb;
          end
        end
      end
      REQ: begin
        if (bus.dmem_req_ready) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.dmem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      err_q   <= err_d;
    end
  end

  assign bus.st_ready       = (state_q == IDLE);
  assign bus.stall_MEM      = (state_q != IDLE) | (bus.st_valid & ~bus.st_ready);
  assign bus.dmem_req_valid = (state_q == REQ);
  assign bus.dmem_req_addr  = addr_q;
  assign bus.dmem_req_wdata = wdata_q;
  assign bus.dmem_req_wstrb = wstrb_q;
  assign bus.store_err      = err_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: directed vector table, hand-written reset/backpressure sequences,
// and randomized stores checked against a byte-lane reference model.
module tb_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  store_unit_if #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(32)) bus ();

  store_unit #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  typedef struct packed {
    logic        issue;
    logic        err;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int          rdy_wait;
    exp_t        e;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [67:0] exp_q[$];
  logic [67:0] mon_got;
  logic [67:0] mon_want;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard: every accepted memory write must match the oldest expected write.
  always @(posedge clk) begin
    if (bus.dmem_req_valid && bus.dmem_req_ready) begin
      mon_got = {bus.dmem_req_addr, bus.dmem_req_wstrb, bus.dmem_req_wdata};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected_req: got %0h, required no request", mon_got);
      end else begin
        mon_want = exp_q.pop_front();
        check("sb_write", mon_got, mon_want);
      end
    end
  end

  // Reference: a store of `size` bytes covers lanes [base, base+size) of its word,
  // and every lane carries data byte (lane mod size).
  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int size;
    int base;
    e = '0;
    case (f3)
      3'b000:  size = 1;
      3'b001:  size = 2;
      3'b010:  size = 4;
      default: size = 0;
    endcase
    if (size == 0) begin
      e.err = 1'b1;
      return e;
    end
`ifdef STORE_MISALIGN_TRAP_EN
    if ((addr % size) != 0) begin
      e.err = 1'b1;
      return e;
    end
`endif
    base = int'(addr % 4);
    base = base - (base % size);
    for (int i = 0; i < 4; i++) begin
      e.wdata[8*i +: 8] = data[8*(i % size) +: 8];
      e.strb[i]         = (i >= base) && (i < base + size);
    end
    e.issue = 1'b1;
    e.addr  = addr - (addr % 4);
    return e;
  endfunction

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                              input int rw, input logic issue, input logic err,
                              input logic [31:0] eaddr, input logic [3:0] strb, input logic [31:0] wdata);
    vec_t v;
    v.f3 = f3; v.addr = addr; v.data = data; v.rdy_wait = rw;
    v.e.issue = issue; v.e.err = err; v.e.addr = eaddr; v.e.strb = strb; v.e.wdata = wdata;
    return v;
  endfunction

  // Entered and left #1 after a rising edge with the unit idle.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input int rdy_wait, input int resp_wait, input exp_t e);
    bus.st_valid        = 1'b1;
    bus.st_funct3       = f3;
    bus.st_addr         = addr;
    bus.st_wdata        = data;
    bus.dmem_req_ready  = 1'b0;
    bus.dmem_resp_valid = 1'b0;
    if (e.issue) exp_q.push_back({e.addr, e.strb, e.wdata});
    @(negedge clk);
    check({tag, "_st_ready_idle"}, bus.st_ready, 1);
    check({tag, "_stall_idle"}, bus.stall_MEM, 0);
    @(posedge clk); #1;
    bus.st_valid  = 1'b0;
    bus.st_addr   = $urandom;
    bus.st_wdata  = $urandom;
    bus.st_funct3 = 3'($urandom_range(0, 7));
    if (!e.issue) begin
      @(negedge clk);
      check({tag, "_err_pulse"}, bus.store_err, 1);
      check({tag, "_no_req"}, bus.dmem_req_valid, 0);
      check({tag, "_ready_after_err"}, bus.st_ready, 1);
      @(posedge clk); #1;
      check({tag, "_err_one_cycle"}, bus.store_err, 0);
      check({tag, "_still_no_req"}, bus.dmem_req_valid, 0);
      return;
    end
    for (int i = 0; i <= rdy_wait; i++) begin
      bus.dmem_req_ready  = (i == rdy_wait);
      bus.dmem_resp_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({tag, "_req_valid"}, bus.dmem_req_valid, 1);
      check({tag, "_req_addr"}, bus.dmem_req_addr, e.addr);
      check({tag, "_req_wstrb"}, bus.dmem_req_wstrb, e.strb);
      check({tag, "_req_wdata"}, bus.dmem_req_wdata, e.wdata);
      check({tag, "_stall_req"}, bus.stall_MEM, 1);
      check({tag, "_err_req"}, bus.store_err, 0);
      @(posedge clk); #1;
    end
    bus.dmem_req_ready = 1'b0;
    for (int j = 0; j <= resp_wait; j++) begin
      bus.dmem_resp_valid = (j == resp_wait);
      @(negedge clk);
      check({tag, "_wait_no_req"}, bus.dmem_req_valid, 0);
      check({tag, "_wait_busy"}, bus.st_ready, 0);
      check({tag, "_wait_stall"}, bus.stall_MEM, 1);
      @(posedge clk); #1;
    end
    bus.dmem_resp_valid = 1'b0;
    check({tag, "_ready_again"}, bus.st_ready, 1);
    check({tag, "_no_err"}, bus.store_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    exp_t e;
    logic [2:0] f3;
    int r;

    vecs.push_back(mk(3'b000, 32'h1003, 32'h000000AB, 0, 1, 0, 32'h1000, 4'b1000, 32'hABABABAB));
    vecs.push_back(mk(3'b001, 32'h2002, 32'h0000BEEF, 4, 1, 0, 32'h2000, 4'b1100, 32'hBEEFBEEF));
    vecs.push_back(mk(3'b011, 32'h5000, 32'h11111111, 0, 0, 1, 32'h0, 4'b0000, 32'h0));
    vecs.push_back(mk(3'b000, 32'h0010, 32'hDEADBE12, 0, 1, 0, 32'h0010, 4'b0001, 32'h12121212));
    vecs.push_back(mk(3'b001, 32'h0020, 32'hCAFE5678, 1, 1, 0, 32'h0020, 4'b0011, 32'h56785678));
    vecs.push_back(mk(3'b000, 32'h0101, 32'h00000034, 2, 1, 0, 32'h0100, 4'b0010, 32'h34343434));
    vecs.push_back(mk(3'b100, 32'h0200, 32'h22222222, 0, 0, 1, 32'h0, 4'b0000, 32'h0));
    vecs.push_back(mk(3'b111, 32'h0300, 32'h33333333, 0, 0, 1, 32'h0, 4'b0000, 32'h0));
    vecs.push_back(mk(3'b010, 32'h7008, 32'hA5A50F0F, 0, 1, 0, 32'h7008, 4'b1111, 32'hA5A50F0F));
`ifdef STORE_MISALIGN_TRAP_EN
    vecs.push_back(mk(3'b010, 32'h3001, 32'h12345678, 0, 0, 1, 32'h0, 4'b0000, 32'h0));
    vecs.push_back(mk(3'b001, 32'h0033, 32'h00001234, 0, 0, 1, 32'h0, 4'b0000, 32'h0));
`else
    vecs.push_back(mk(3'b010, 32'h3001, 32'h12345678, 0, 1, 0, 32'h3000, 4'b1111, 32'h12345678));
    vecs.push_back(mk(3'b001, 32'h0033, 32'h00001234, 0, 1, 0, 32'h0030, 4'b1100, 32'h12341234));
`endif

    // Reset with a store pending on the input.
    rst_n               = 1'b0;
    bus.st_valid        = 1'b1;
    bus.st_addr         = 32'h1234;
    bus.st_wdata        = 32'h5555AAAA;
    bus.st_funct3       = 3'b010;
    bus.dmem_req_ready  = 1'b0;
    bus.dmem_resp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", bus.dmem_req_valid, 0);
    check("rst_wstrb", bus.dmem_req_wstrb, 0);
    check("rst_wdata", bus.dmem_req_wdata, 0);
    check("rst_addr", bus.dmem_req_addr, 0);
    check("rst_err", bus.store_err, 0);
    check("rst_st_ready", bus.st_ready, 1);
    check("rst_stall", bus.stall_MEM, 0);
    bus.st_valid = 1'b0;
    rst_n        = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[k]) begin
      do_store($sformatf("vec%0d", k), vecs[k].f3, vecs[k].addr, vecs[k].data,
               vecs[k].rdy_wait, 0, vecs[k].e);
    end

    // Reset while waiting for the acknowledge; a late acknowledge must be ignored.
    bus.st_valid       = 1'b1;
    bus.st_funct3      = 3'b010;
    bus.st_addr        = 32'h6004;
    bus.st_wdata       = 32'h0BADF00D;
    bus.dmem_req_ready = 1'b1;
    exp_q.push_back({32'h6004, 4'b1111, 32'h0BADF00D});
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
    @(posedge clk); #1;
    bus.dmem_req_ready = 1'b0;
    check("ack_rst_in_wait", bus.st_ready, 0);
    check("ack_rst_wait_noreq", bus.dmem_req_valid, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n               = 1'b1;
    bus.dmem_resp_valid = 1'b1;
    check("ack_rst_idle", bus.st_ready, 1);
    check("ack_rst_addr", bus.dmem_req_addr, 0);
    check("ack_rst_wstrb", bus.dmem_req_wstrb, 0);
    @(posedge clk); #1;
    bus.dmem_resp_valid = 1'b0;
    check("ack_ignored_idle", bus.st_ready, 1);
    check("ack_ignored_noreq", bus.dmem_req_valid, 0);
    check("ack_ignored_stall", bus.stall_MEM, 0);
    do_store("after_rst", 3'b010, 32'h4000, 32'hC001D00D, 0, 0, model(3'b010, 32'h4000, 32'hC001D00D));

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      f3 = 3'b000;
      else if (r < 6) f3 = 3'b001;
      else if (r < 9) f3 = 3'b010;
      else            f3 = 3'($urandom_range(3, 7));
      bus.st_addr = $urandom;
      e = model(f3, bus.st_addr, 32'(n * 32'h01010101) ^ 32'h5A3C96E1);
      do_store($sformatf("rnd%0d", n), f3, bus.st_addr, 32'(n * 32'h01010101) ^ 32'h5A3C96E1,
               $urandom_range(0, 3), $urandom_range(0, 2), e);
    end

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 68'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
